uart_rx_cfg: RTL and testbench

- Runtime-configurable UART receiver; next generation of the fixed 8N1 receiver in the UART library.
- Adds 5–8 data bits, none/even/odd parity, 1 or 2 stop bits, parameterised oversampling, and a valid/ready output handshake.
- Reports framing, parity and overrun errors.
- Sits between the pad synchroniser input and the host-side byte FIFO or register interface.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_baud_tick.sv | 31 +++
 rtl/uart_rx_cfg.sv | 260 ++++++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver and its companion TX.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_mode_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // The reserved encoding 3 collapses onto "no parity".
    function automatic parity_mode_t decode_parity(input logic [1:0] raw);
        case (raw)
            2'd1:    return PAR_EVEN;
            2'd2:    return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock pulse every CLKS_PER_TICK clocks, phase restartable.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_TICK = 1
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam int unsigned CW = cnt_width(CLKS_PER_TICK);
    localparam logic [CW-1:0] TERMINAL = CW'(CLKS_PER_TICK - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == TERMINAL)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // A restart suppresses the tick so the first tick lands a full period later.
    assign o_tick = (r_cnt == TERMINAL) && !i_restart;

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver (5-8 data bits, none/even/odd parity, 1-2 stop bits).
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned FREQUENCY  = 10_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_serial,
    input  logic [1:0] cfg_data_bits,
    input  logic [1:0] cfg_parity,
    input  logic       cfg_two_stop,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_byte,
    output logic       rx_frame_err,
    output logic       rx_parity_err,
    output logic       rx_overrun,
    output logic       rx_busy,
    output rx_state_t  dbg_state
);

    localparam int unsigned CLKS_PER_TICK = FREQUENCY / (OVERSAMPLE * BAUD_RATE);
    localparam int unsigned SW = cnt_width(OVERSAMPLE);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [SW-1:0] START_DEC = SW'(OVERSAMPLE / 2);
`else
    localparam logic [SW-1:0] START_DEC = SW'(OVERSAMPLE / 2 - 1);
`endif
    localparam logic [SW-1:0] BIT_DEC = SW'(OVERSAMPLE - 1);

    if (CLKS_PER_TICK == 0) begin : g_bad_tick
        $error("uart_rx_cfg: FREQUENCY too low for OVERSAMPLE*BAUD_RATE");
    end
    if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
        $error("uart_rx_cfg: OVERSAMPLE must be even and at least 8");
    end

    logic [1:0]    r_sync;
    logic          r_line_q;
    logic          w_line;
    logic          w_tick;
    logic          w_restart;
    logic          w_sample;
    logic [SW-1:0] w_dec;
    logic          w_at_dec;

    rx_state_t     r_state, w_state_n;
    logic [SW-1:0] r_s, w_s_n;
    logic [2:0]    r_idx, w_idx_n;
    logic [7:0]    r_data, w_data_n;
    logic          r_par, w_par_n;
    logic          r_perr, w_perr_n;
    logic          r_ferr, w_ferr_n;
    logic          r_stop_idx, w_stop_idx_n;
    logic          r_done, w_done_n;
    logic [1:0]    r_cfg_bits, w_cfg_bits_n;
    parity_mode_t  r_cfg_par, w_cfg_par_n;
    logic          r_cfg_two, w_cfg_two_n;
    logic [2:0]    w_last_idx;

    logic          r_valid;
    logic [7:0]    r_byte;
    logic          r_frame_err;
    logic          r_parity_err;
    logic          r_overrun;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync   <= 2'b11;
            r_line_q <= 1'b1;
        end else begin
            r_sync   <= {r_sync[0], rx_serial};
            r_line_q <= r_sync[1];
        end
    end

    assign w_line    = r_sync[1];
    assign w_restart = (r_state == IDLE) && !w_line && r_line_q;

    uart_baud_tick #(
        .CLKS_PER_TICK(CLKS_PER_TICK)
    ) u_tick (
        .i_clk    (clk),
        .i_reset_n(reset_n),
        .i_restart(w_restart),
        .o_tick   (w_tick)
    );

    assign w_dec      = (r_state == START) ? START_DEC : BIT_DEC;
    assign w_at_dec   = w_tick && (r_s == w_dec);
    assign w_last_idx = 3'd4 + {1'b0, r_cfg_bits};

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_maj;

    // Capture centre-1 and centre; the decision tick supplies centre+1 live.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_maj <= 2'b11;
        end else if (w_tick) begin
            if (r_s == (w_dec - SW'(2))) r_maj[0] <= w_line;
            if (r_s == (w_dec - SW'(1))) r_maj[1] <= w_line;
        end
    end

    assign w_sample = (r_maj[0] & r_maj[1]) | (r_maj[0] & w_line) | (r_maj[1] & w_line);
`else
    assign w_sample = w_line;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_s        <= '0;
            r_idx      <= '0;
            r_data     <= '0;
            r_par      <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_stop_idx <= 1'b0;
            r_done     <= 1'b0;
            r_cfg_bits <= '0;
            r_cfg_par  <= PAR_NONE;
            r_cfg_two  <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_s        <= w_s_n;
            r_idx      <= w_idx_n;
            r_data     <= w_data_n;
            r_par      <= w_par_n;
            r_perr     <= w_perr_n;
            r_ferr     <= w_ferr_n;
            r_stop_idx <= w_stop_idx_n;
            r_done     <= w_done_n;
            r_cfg_bits <= w_cfg_bits_n;
            r_cfg_par  <= w_cfg_par_n;
            r_cfg_two  <= w_cfg_two_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_s_n        = r_s;
        w_idx_n      = r_idx;
        w_data_n     = r_data;
        w_par_n      = r_par;
        w_perr_n     = r_perr;
        w_ferr_n     = r_ferr;
        w_stop_idx_n = r_stop_idx;
        w_done_n     = 1'b0;
        w_cfg_bits_n = r_cfg_bits;
        w_cfg_par_n  = r_cfg_par;
        w_cfg_two_n  = r_cfg_two;

        case (r_state)
            IDLE: begin
                // Falling edge only: a held-low line (break) never re-triggers.
                if (w_restart) begin
                    w_state_n    = START;
                    w_s_n        = '0;
                    w_idx_n      = '0;
                    w_data_n     = '0;
                    w_par_n      = 1'b0;
                    w_perr_n     = 1'b0;
                    w_ferr_n     = 1'b0;
                    w_stop_idx_n = 1'b0;
                    w_cfg_bits_n = cfg_data_bits;
                    w_cfg_par_n  = decode_parity(cfg_parity);
                    w_cfg_two_n  = cfg_two_stop;
                end
            end
            START: begin
                if (w_at_dec) begin
                    w_s_n     = '0;
                    w_state_n = w_sample ? IDLE : DATA;
                end else if (w_tick) begin
                    w_s_n = r_s + SW'(1);
                end
            end
            DATA: begin
                if (w_at_dec) begin
                    w_s_n           = '0;
                    w_data_n[r_idx] = w_sample;
                    w_par_n         = r_par ^ w_sample;
                    if (r_idx == w_last_idx) begin
                        w_idx_n   = '0;
                        w_state_n = (r_cfg_par == PAR_NONE) ? STOP : PARITY;
                    end else begin
                        w_idx_n = r_idx + 3'd1;
                    end
                end else if (w_tick) begin
                    w_s_n = r_s + SW'(1);
                end
            end
            PARITY: begin
                if (w_at_dec) begin
                    w_s_n     = '0;
                    w_perr_n  = (r_par ^ w_sample) != (r_cfg_par == PAR_ODD);
                    w_state_n = STOP;
                end else if (w_tick) begin
                    w_s_n = r_s + SW'(1);
                end
            end
            STOP: begin
                if (w_at_dec) begin
                    w_s_n = '0;
                    if (!w_sample) w_ferr_n = 1'b1;
                    if (r_cfg_two && !r_stop_idx) begin
                        w_stop_idx_n = 1'b1;
                    end else begin
                        w_state_n = IDLE;
                        w_done_n  = 1'b1;
                    end
                end else if (w_tick) begin
                    w_s_n = r_s + SW'(1);
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    // Output word: valid holds byte/flags stable until a cycle with valid & ready.
    // A completion arriving while an unaccepted word is held is dropped and flagged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid      <= 1'b0;
            r_byte       <= '0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (r_done) begin
            if (!r_valid || rx_ready) begin
                r_valid      <= 1'b1;
                r_byte       <= r_data;
                r_frame_err  <= r_ferr;
                r_parity_err <= r_perr;
                if (r_valid) r_overrun <= 1'b0;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && rx_ready) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign rx_valid      = r_valid;
    assign rx_byte       = r_byte;
    assign rx_frame_err  = r_frame_err;
    assign rx_parity_err = r_parity_err;
    assign rx_overrun    = r_overrun;
    assign rx_busy       = (r_state != IDLE);
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg at 160 clocks per bit (1.6 MHz, 10 kbaud, x16).
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int BIT = 160;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_serial;
    logic [1:0] cfg_data_bits;
    logic [1:0] cfg_parity;
    logic       cfg_two_stop;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] rx_byte;
    logic       rx_frame_err;
    logic       rx_parity_err;
    logic       rx_overrun;
    logic       rx_busy;
    rx_state_t  dbg_state;

    int checks = 0;
    int failures = 0;
    int hs_count = 0;
    int valid_cycles = 0;
    int hs0;
    int vc0;
    logic [7:0] cap_byte = 8'h00;
    logic       cap_fe = 1'b0;
    logic       cap_pe = 1'b0;

    uart_rx_cfg #(
        .FREQUENCY (1_600_000),
        .BAUD_RATE (10_000),
        .OVERSAMPLE(16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_serial    (rx_serial),
        .cfg_data_bits(cfg_data_bits),
        .cfg_parity   (cfg_parity),
        .cfg_two_stop (cfg_two_stop),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_byte      (rx_byte),
        .rx_frame_err (rx_frame_err),
        .rx_parity_err(rx_parity_err),
        .rx_overrun   (rx_overrun),
        .rx_busy      (rx_busy),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    // Records each handshake the DUT is about to see at the coming rising edge.
    always @(negedge clk) begin
        #1;
        if (rx_valid) valid_cycles++;
        if (rx_valid && rx_ready) begin
            cap_byte = rx_byte;
            cap_fe   = rx_frame_err;
            cap_pe   = rx_parity_err;
            hs_count++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx_serial = v;
        repeat (BIT) @(negedge clk);
    endtask

    // par: 0 none, 1 even, 2 odd. One idle bit follows every frame.
    task automatic send_frame(input logic [7:0] d, input int nbits, input logic [1:0] par,
                              input logic flip, input logic two, input logic stop2_low);
        logic p;
        cfg_data_bits = 2'(nbits - 5);
        cfg_parity    = par;
        cfg_two_stop  = two;
        p = 1'b0;
        drive_bit(1'b0);
        for (int k = 0; k < nbits; k++) begin
            drive_bit(d[k]);
            p = p ^ d[k];
        end
        if (par == 2'd1 || par == 2'd2) drive_bit(((par == 2'd2) ? ~p : p) ^ flip);
        drive_bit(1'b1);
        if (two) drive_bit(stop2_low ? 1'b0 : 1'b1);
        drive_bit(1'b1);
    endtask

    initial begin
        reset_n       = 1'b0;
        rx_serial     = 1'b1;
        cfg_data_bits = 2'd3;
        cfg_parity    = 2'd0;
        cfg_two_stop  = 1'b0;
        rx_ready      = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_valid", rx_valid, 0);
        chk("reset_byte", rx_byte, 0);
        chk("reset_flags", {rx_frame_err, rx_parity_err, rx_overrun}, 0);
        chk("reset_busy", rx_busy, 0);
        reset_n = 1'b1;
        repeat (BIT) @(negedge clk);

        // 8N1 0xA5 with the consumer always ready
        hs0 = hs_count;
        vc0 = valid_cycles;
        send_frame(8'hA5, 8, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("8n1_handshakes", hs_count - hs0, 1);
        chk("8n1_byte", cap_byte, 8'hA5);
        chk("8n1_errs", {cap_fe, cap_pe}, 0);
        chk("8n1_valid_pulse_len", valid_cycles - vc0, 1);
        chk("8n1_valid_low_after", rx_valid, 0);

        // 7E1 0x35, correct parity then flipped parity
        send_frame(8'h35, 7, 2'd1, 1'b0, 1'b0, 1'b0);
        chk("7e1_byte", cap_byte, 8'h35);
        chk("7e1_errs", {cap_fe, cap_pe}, 2'b00);
        send_frame(8'h35, 7, 2'd1, 1'b1, 1'b0, 1'b0);
        chk("7e1_bad_byte", cap_byte, 8'h35);
        chk("7e1_bad_errs", {cap_fe, cap_pe}, 2'b01);

        // 5O2 0x1F, second stop bit low
        send_frame(8'h1F, 5, 2'd2, 1'b0, 1'b1, 1'b1);
        chk("5o2_byte", cap_byte, 8'h1F);
        chk("5o2_errs", {cap_fe, cap_pe}, 2'b10);
        chk("5o2_busy_after", rx_busy, 0);

        // Overrun with the consumer stalled
        rx_ready = 1'b0;
        hs0 = hs_count;
        send_frame(8'h11, 8, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("ovr_first_valid", rx_valid, 1);
        chk("ovr_first_byte", rx_byte, 8'h11);
        chk("ovr_first_flag", rx_overrun, 0);
        send_frame(8'h22, 8, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("ovr_second_valid", rx_valid, 1);
        chk("ovr_second_byte", rx_byte, 8'h11);
        chk("ovr_second_flag", rx_overrun, 1);
        rx_ready = 1'b1;
        @(negedge clk);
        chk("ovr_hs_valid", rx_valid, 0);
        chk("ovr_hs_flag", rx_overrun, 0);
        chk("ovr_hs_count", hs_count - hs0, 1);
        chk("ovr_hs_byte", cap_byte, 8'h11);

        // 6-clock glitch on the idle line
        hs0 = hs_count;
        vc0 = valid_cycles;
        rx_serial = 1'b0;
        repeat (6) @(negedge clk);
        rx_serial = 1'b1;
        repeat (4) @(negedge clk);
        chk("glitch_busy_start", rx_busy, 1);
        repeat (BIT) @(negedge clk);
        chk("glitch_busy_end", rx_busy, 0);
        chk("glitch_no_valid", valid_cycles - vc0, 0);

        // Reset in the middle of data bit 2 of 0x5A, then a clean 0x3C
        cfg_data_bits = 2'd3;
        cfg_parity    = 2'd0;
        cfg_two_stop  = 1'b0;
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rx_serial = 1'b0;
        repeat (BIT / 2) @(negedge clk);
        chk("rst_mid_busy_before", rx_busy, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_byte", rx_byte, 0);
        chk("rst_mid_valid_busy", {rx_valid, rx_busy}, 0);
        @(negedge clk);
        rx_serial = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (BIT) @(negedge clk);
        hs0 = hs_count;
        send_frame(8'h3C, 8, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_handshakes", hs_count - hs0, 1);
        chk("post_rst_byte", cap_byte, 8'h3C);
        chk("post_rst_errs", {cap_fe, cap_pe}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
